virtio_available_ring_scheduler: RTL
====================================

Name: virtio_available_ring_scheduler

Overview:
Round-robin scheduler that shares one memory-read request channel between QUEUES available ring handlers, one per virtqueue. It accepts single-beat requests (request type on tid, length/offset on tdata), arbitrates fairly and forwards the winner on a registered AXI4-Stream output tagged with the queue index on tdest. It limits each queue's in-flight reads using completion tokens returned by the memory reader.

Parameters:
QUEUES, 4, number of requesting ring handlers (>=1)
TID_WIDTH, 2, request type width
TDATA_WIDTH, 32, request payload width (16-bit length + 16-bit offset)
MAX_OUTSTANDING, 4, max in-flight requests per queue (>=1)

Ports:
aclk  in  1  clock
areset  in  1  reset, synchronous, active-high
rx_tvalid  in  QUEUES  per-queue request valid
rx_tready  out  QUEUES  per-queue request accept
rx_tid  in  QUEUES*TID_WIDTH  per-queue request type, queue i at [i*TID_WIDTH +: TID_WIDTH]
rx_tdata  in  QUEUES*TDATA_WIDTH  per-queue request payload, same packing
tx_tvalid  out  1  granted request valid
tx_tready  in  1  downstream accept
tx_tid  out  TID_WIDTH  forwarded request type
tx_tdata  out  TDATA_WIDTH  forwarded payload
tx_tdest  out  QW  source queue index, QW = max(1, $clog2(QUEUES))
done_tvalid  in  1  one completion token (always accepted)
done_tdest  in  QW  queue the completion belongs to
error  out  1  sticky: completion received for a queue with zero outstanding, or done_tdest >= QUEUES

Behaviour:
- Single clock aclk; reset is synchronous and active-high (areset sampled on the aclk rising edge).
- Reset values: tx_tvalid=0, tx_tid/tx_tdata/tx_tdest=0, error=0, all outstanding counters=0, round-robin pointer=QUEUES-1 (so queue 0 wins first). rx_tready=0 while areset=1.
- Reset mid-operation: any held request and all counts are discarded. Upstream handlers are reset alongside this block.
- eligible[i] = rx_tvalid[i] && (outstanding[i] < MAX_OUTSTANDING).
- Output slot free = !tx_tvalid || tx_tready.
- When the slot is free and any queue is eligible: grant the first eligible index searching pointer+1, pointer+2, ... with wrap modulo QUEUES.
- The grant is combinational in the same cycle: rx_tready[g]=1, all other bits 0. At most one rx_tready bit is set per cycle.
- On grant, next cycle: tx_tvalid=1; tx_tid/tx_tdata = queue g's tid/tdata; tx_tdest=g; pointer=g.
- Latency from rx handshake to tx_tvalid is 1 cycle. Sustained throughput is one request per cycle when tx_tready=1.
- Slot free with no eligible queue: tx_tvalid drops to 0 after a tx handshake; pointer unchanged.
- Backpressure: while tx_tvalid && !tx_tready, tx_tid/tx_tdata/tx_tdest stay stable and all rx_tready=0.
- outstanding[i] is $clog2(MAX_OUTSTANDING+1) bits wide.
  - Increments on the rx grant to i, so a request held in the output register already counts.
  - Decrements on done_tvalid with done_tdest==i.
  - Increment and decrement in the same cycle: value unchanged.
- A decrement at 0 is ignored (counter stays 0) and sets error. done_tdest >= QUEUES also sets error. error clears only on reset.
- A queue at MAX_OUTSTANDING is skipped by arbitration. It becomes eligible in the cycle after its completion arrives, not the same cycle (the arbiter uses the registered count).
- QUEUES=1: pointer is constant 0 and tx_tdest=0. The block degenerates to a registered slice with credit limiting.
- The rx side holds no request storage: handlers keep tvalid/tid/tdata stable until their rx_tready.

Test Plan:
- Reset then all 4 queues valid continuously, tx_tready=1, done_tvalid pulsed every cycle for the queue just granted -> tx_tdest sequence 0,1,2,3,0,1,... with one tx beat per cycle after the first cycle; error=0.
- Only queue 2 valid with payload 0x0010_0040, tid=1 -> rx_tready=0b0100 in the request cycle; next cycle tx_tvalid=1, tx_tdata=0x0010_0040, tx_tid=1, tx_tdest=2.
- tx_tready=0 for 5 cycles while a beat from queue 1 is held -> tx_* stable, rx_tready=0 throughout; after tx_tready=1, next grant goes to queue 2 (not queue 0).
- Queue 3 alone, MAX_OUTSTANDING=4, no completions -> exactly 4 grants, then rx_tready[3] stays 0. One done_tvalid with tdest=3 -> exactly one more grant, issued the cycle after the completion.
- Same-cycle grant and done_tvalid for queue 0 at outstanding=2 -> count stays 2. done_tvalid with tdest=1 at outstanding=0 -> error=1, count stays 0, error persists until areset.
- Assert areset for 1 cycle while tx_tvalid=1 and counts are non-zero -> next cycle tx_tvalid=0, error=0, counts 0; first grant afterwards goes to queue 0.

Source files
------------

// File: rtl/virtio_available_ring_scheduler.sv
// Round-robin scheduler sharing one memory-read request stream among virtqueue ring handlers,
// with per-queue in-flight limiting driven by completion tokens from the memory reader.
module virtio_available_ring_scheduler #(
  parameter int unsigned QUEUES          = 4,
  parameter int unsigned TID_WIDTH       = 2,
  parameter int unsigned TDATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned QW = (QUEUES > 1) ? $clog2(QUEUES) : 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [QUEUES-1:0]             rx_tvalid,
  output logic [QUEUES-1:0]             rx_tready,
  input  logic [QUEUES*TID_WIDTH-1:0]   rx_tid,
  input  logic [QUEUES*TDATA_WIDTH-1:0] rx_tdata,
  output logic                          tx_tvalid,
  input  logic                          tx_tready,
  output logic [TID_WIDTH-1:0]          tx_tid,
  output logic [TDATA_WIDTH-1:0]        tx_tdata,
  output logic [QW-1:0]                 tx_tdest,
  input  logic                          done_tvalid,
  input  logic [QW-1:0]                 done_tdest,
  output logic                          error
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]          cnt_q [QUEUES];
  logic [QW-1:0]          ptr_q;
  logic                   tx_tvalid_q;
  logic [TID_WIDTH-1:0]   tx_tid_q;
  logic [TDATA_WIDTH-1:0] tx_tdata_q;
  logic [QW-1:0]          tx_tdest_q;
  logic                   error_q;

  logic [QUEUES-1:0]      eligible;
  logic [QUEUES-1:0]      dec_vec;
  logic [QUEUES-1:0]      underflow_vec;
  logic                   slot_free;
  logic                   take;
  logic                   gnt_found;
  logic [QW-1:0]          gnt_idx;
  logic [QW-1:0]          cand;
  logic [TID_WIDTH-1:0]   sel_tid;
  logic [TDATA_WIDTH-1:0] sel_tdata;
  logic                   done_bad;

  // Eligibility uses the registered count, so a completion frees a slot one cycle later.
  always_comb begin
    eligible      = '0;
    dec_vec       = '0;
    underflow_vec = '0;
    for (int unsigned i = 0; i < QUEUES; i++) begin
      eligible[i]      = rx_tvalid[i] && (cnt_q[i] < MaxCnt);
      dec_vec[i]       = done_tvalid && (done_tdest == QW'(i)) && (cnt_q[i] != '0);
      underflow_vec[i] = done_tvalid && (done_tdest == QW'(i)) && (cnt_q[i] == '0);
    end
  end

  assign done_bad  = done_tvalid && (32'(done_tdest) >= QUEUES);
  assign slot_free = !tx_tvalid_q || tx_tready;

  // First eligible queue after the pointer, wrapping modulo QUEUES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= QUEUES; k++) begin
      cand = QW'((32'(ptr_q) + k) % QUEUES);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign take = !areset && slot_free && gnt_found;

  always_comb begin
    rx_tready = '0;
    if (take) begin
      rx_tready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_tid   = '0;
    sel_tdata = '0;
    for (int unsigned i = 0; i < QUEUES; i++) begin
      if (QW'(i) == gnt_idx) begin
        sel_tid   = rx_tid[i*TID_WIDTH +: TID_WIDTH];
        sel_tdata = rx_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tx_tvalid_q <= 1'b0;
      tx_tid_q    <= '0;
      tx_tdata_q  <= '0;
      tx_tdest_q  <= '0;
      ptr_q       <= QW'(QUEUES - 1);
      error_q     <= 1'b0;
    end else begin
      if (take) begin
        tx_tvalid_q <= 1'b1;
        tx_tid_q    <= sel_tid;
        tx_tdata_q  <= sel_tdata;
        tx_tdest_q  <= gnt_idx;
        ptr_q       <= gnt_idx;
      end else if (tx_tready) begin
        tx_tvalid_q <= 1'b0;
      end
      if (done_bad || (|underflow_vec)) begin
        error_q <= 1'b1;
      end
    end
  end

  // A grant counts immediately, even while the beat still sits in the output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < QUEUES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < QUEUES; i++) begin
        if (rx_tready[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else if (!rx_tready[i] && dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tid    = tx_tid_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tdest  = tx_tdest_q;
  assign error     = error_q;

endmodule
